// File: rtl/queue_credit_arbiter.sv
// Two-requester round-robin arbiter feeding a shared Queue under credit flow control.
// Optional simulation checkers: define QUEUE_CREDIT_ARBITER_ASSERT_EN.
module queue_credit_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    output logic              enq_valid,
    output logic [DATA_W-1:0] enq_data,
    output logic              enq_src,
    input  logic              credit_ret,
    output logic [CNT_W-1:0]  credits,
    output logic              idle
);

    localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(DEPTH);

    logic              ptr;
    logic              have_credit;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [CNT_W-1:0]  credits_next;
    logic [DATA_W-1:0] sel_data;

    // Ready equals grant, so a grant against a valid request is always a transfer.
    always_comb begin
        have_credit = (credits != '0);
        grant0      = have_credit && req0_valid && (!req1_valid || !ptr);
        grant1      = have_credit && req1_valid && (!req0_valid ||  ptr);
        xfer        = grant0 || grant1;
        sel_data    = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        credits_next = credits;
        if (xfer && !credit_ret) begin
            credits_next = credits - 1'b1;
        end else if (!xfer && credit_ret && (credits != FULL_CREDITS)) begin
            credits_next = credits + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credits   <= FULL_CREDITS;
            ptr       <= 1'b0;
            enq_valid <= 1'b0;
            enq_data  <= '0;
            enq_src   <= 1'b0;
        end else begin
            credits   <= credits_next;
            enq_valid <= xfer;
            if (xfer) begin
                enq_data <= sel_data;
                enq_src  <= grant1;
                ptr      <= ~grant1;
            end
        end
    end

    assign idle = (credits == FULL_CREDITS) && !enq_valid;

`ifdef QUEUE_CREDIT_ARBITER_ASSERT_EN
`ifndef SYNTHESIS
    wire print_ok = 1'b1;
    wire stop_ok  = 1'b1;

    // Entries already resident in the Queue, excluding the beat being enqueued now.
    int resident;
    always_comb resident = DEPTH - int'(credits) - int'(enq_valid);

    always @(posedge clock) begin
        if (reset_n) begin
            if (credit_ret && (credits == FULL_CREDITS) && !xfer) begin
                if (print_ok) $display("credit overflow");
                if (stop_ok)  $fatal(1, "credit overflow");
            end
            if (enq_valid && (resident == DEPTH)) begin
                if (print_ok) $display("enqueue while full");
                if (stop_ok)  $fatal(1, "enqueue while full");
            end
            if (req0_ready && req1_ready) begin
                if (print_ok) $display("double grant");
                if (stop_ok)  $fatal(1, "double grant");
            end
        end
    end
`endif
`endif

endmodule
